// File: rtl/clk_enable_nco.sv
// Multi-channel phase-accumulator clock-enable generator: each channel wraps at
// f_clock*inc/2^ACC_W and emits a strobe, a square wave and a settled flag.
module clk_enable_nco #(
  parameter int               NUM_CH       = 2,
  parameter int               ACC_W        = 24,
  parameter logic [ACC_W-1:0] DEFAULT_INC  = ACC_W'(24'h400000),
  parameter int               SETTLE_WRAPS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_sync,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] locked
);

  localparam int              CNT_W     = $clog2(SETTLE_WRAPS + 1);
  localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_WRAPS);
  localparam logic [4:0]      LP_NUM_CH = 5'(NUM_CH);

  logic [ACC_W-1:0]  r_acc      [NUM_CH];
  logic [ACC_W-1:0]  r_inc      [NUM_CH];
  logic [ACC_W-1:0]  r_pend_inc [NUM_CH];
  logic [CNT_W-1:0]  r_settle   [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_sq;
  logic [NUM_CH-1:0] r_locked;
  logic              r_err;

  logic [ACC_W:0]    w_sum     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_carry;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_hit;
  logic              w_bad;
  logic              w_xfer;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sum[ch]     = {1'b0, r_acc[ch]} + {1'b0, r_inc[ch]};
      w_carry[ch]   = w_sum[ch][ACC_W];
      w_sel[ch]     = (cfg_ch == 4'(ch));
      w_cnt_nxt[ch] = r_settle[ch] + CNT_W'(1);
    end
  end

  // Out-of-range channels are always accepted so the error pulse can be reported.
  assign w_bad     = ({1'b0, cfg_ch} >= LP_NUM_CH);
  assign cfg_ready = w_bad | ~|(r_pending & w_sel);
  assign w_xfer    = cfg_valid & cfg_ready;
  assign w_hit     = w_xfer ? w_sel : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_pending <= '0;
      r_en      <= '0;
      r_sq      <= '0;
      r_locked  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_acc[ch]      <= '0;
        r_inc[ch]      <= DEFAULT_INC;
        r_pend_inc[ch] <= '0;
        r_settle[ch]   <= '0;
      end
    end else begin
      r_err <= w_xfer & w_bad;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_hit[ch] && (cfg_sync || r_inc[ch] == '0)) begin
          // Immediate apply; a stopped channel keeps its phase unless a restart is requested.
          r_inc[ch]     <= cfg_inc;
          r_acc[ch]     <= cfg_sync ? '0 : w_sum[ch][ACC_W-1:0];
          r_en[ch]      <= 1'b0;
          r_sq[ch]      <= cfg_sync ? 1'b0 : r_sq[ch];
          r_settle[ch]  <= '0;
          r_locked[ch]  <= 1'b0;
          r_pending[ch] <= 1'b0;
        end else begin
          r_acc[ch] <= w_sum[ch][ACC_W-1:0];
          r_en[ch]  <= w_carry[ch];
          r_sq[ch]  <= r_sq[ch] ^ w_carry[ch];
          if (w_hit[ch]) begin
            r_pend_inc[ch] <= cfg_inc;
            r_pending[ch]  <= 1'b1;
          end
          // r_pending is the pre-acceptance value, so a wrap in the accept cycle is ignored.
          if (r_pending[ch] && w_carry[ch]) begin
            r_inc[ch]     <= r_pend_inc[ch];
            r_pending[ch] <= 1'b0;
            r_settle[ch]  <= '0;
            r_locked[ch]  <= 1'b0;
          end else if (w_carry[ch] && !r_locked[ch]) begin
            r_settle[ch] <= w_cnt_nxt[ch];
            if (w_cnt_nxt[ch] == LP_SETTLE) r_locked[ch] <= 1'b1;
          end
        end
      end
    end
  end

  assign en_out  = r_en;
  assign sq_out  = r_sq;
  assign locked  = r_locked;
  assign cfg_err = r_err;

endmodule
